multi_port_perf_readout: RTL and testbench

Parametrised successor to the fixed four-port MAC performance-counter readout. It serves N ports × M counters of configurable width from one management-side clock domain, and adds atomic per-port snapshots, out-of-range error reporting and optional clear-on-read. It sits between the management register bus and the per-port counter blocks, after those counters have been brought into the management domain. Reads are fully pipelined with fixed latency and no back-pressure.

---
 rtl/perf_readout_pkg.sv | 31 +++
 rtl/perf_snapshot_bank.sv | 33 +++
 rtl/multi_port_perf_readout.sv | 170 +++++++++++++++++
 tb/tb_multi_port_perf_readout.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/perf_readout_pkg.sv
// Shared constants and region decode for the multi-port performance-counter readout.
package perf_readout_pkg;

  localparam logic [7:0] PERF_REGION_LIVE    = 8'h10;
  localparam logic [7:0] PERF_REGION_SNAP    = 8'h11;
  localparam logic [7:0] PERF_REGION_CAPTURE = 8'h12;

  // Per-port counter layout used by the MAC counter blocks.
  localparam int REG_TX_FRAMES   = 0;
  localparam int REG_TX_BYTES    = 1;
  localparam int REG_RX_FRAMES   = 2;
  localparam int REG_RX_CRC_ERRS = 3;
  localparam int REG_RX_BYTES    = 4;

  typedef enum logic [1:0] {
    OP_LIVE    = 2'd0,
    OP_SNAP    = 2'd1,
    OP_CAPTURE = 2'd2,
    OP_BAD     = 2'd3
  } perf_op_e;

  function automatic perf_op_e decode_region(input logic [7:0] region);
    case (region)
      PERF_REGION_LIVE:    return OP_LIVE;
      PERF_REGION_SNAP:    return OP_SNAP;
      PERF_REGION_CAPTURE: return OP_CAPTURE;
      default:             return OP_BAD;
    endcase
  endfunction

endpackage

// File: rtl/perf_snapshot_bank.sv
// One port's snapshot bank: captures the whole counter vector in a single cycle
// and serves indexed reads from the held copy.
module perf_snapshot_bank #(
  parameter int NUM_COUNTERS = 5,
  parameter int CTR_WIDTH    = 48
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              capture,
  input  logic [NUM_COUNTERS*CTR_WIDTH-1:0] ctr_in,
  input  logic [7:0]                        rd_idx,
  output logic [CTR_WIDTH-1:0]              rd_data
);

  logic [NUM_COUNTERS*CTR_WIDTH-1:0] bank;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank <= '0;
    end else if (capture) begin
      bank <= ctr_in;
    end
  end

  // Out-of-range indices read 0; the top level flags them as errors.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (rd_idx == 8'(i)) rd_data = bank[i*CTR_WIDTH +: CTR_WIDTH];
    end
  end

endmodule

// File: rtl/multi_port_perf_readout.sv
// Management-side readout of NUM_PORTS x NUM_COUNTERS counters with live reads,
// per-port atomic snapshots and error reporting. Optional: PERF_CLEAR_ON_READ_EN.
module multi_port_perf_readout
  import perf_readout_pkg::*;
#(
  parameter int NUM_PORTS    = 4,
  parameter int NUM_COUNTERS = 5,
  parameter int CTR_WIDTH    = 48,
  parameter int PORT_BITS    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                                        clk_mgmt,
  input  logic                                        rst_mgmt_n,
  input  logic [NUM_PORTS*NUM_COUNTERS*CTR_WIDTH-1:0] perf_in,
  input  logic                                        rd_en,
  input  logic [PORT_BITS-1:0]                        rd_port,
  input  logic [15:0]                                 rd_addr,
  output logic                                        rd_valid,
  output logic [CTR_WIDTH-1:0]                        rd_data,
  output logic                                        rd_err,
  output logic [NUM_PORTS*NUM_COUNTERS-1:0]           perf_clear
);

  // Handshake: rd_en is accepted every cycle (no ready); each accepted request
  // yields exactly one rd_valid pulse two cycles later, in request order, with
  // rd_data/rd_err qualified by rd_valid and held otherwise.

  logic                 s1_valid;
  logic [PORT_BITS-1:0] s1_port;
  logic [7:0]           s1_region;
  logic [7:0]           s1_idx;

  always_ff @(posedge clk_mgmt) begin
    if (!rst_mgmt_n) begin
      s1_valid  <= 1'b0;
      s1_port   <= '0;
      s1_region <= '0;
      s1_idx    <= '0;
    end else begin
      s1_valid  <= rd_en;
      s1_port   <= rd_port;
      s1_region <= rd_addr[15:8];
      s1_idx    <= rd_addr[7:0];
    end
  end

  // Range checks only exist where the field can actually exceed the limit.
  logic port_oor;
  logic idx_oor;

  if ((1 << PORT_BITS) > NUM_PORTS) begin : g_port_chk
    assign port_oor = (32'(s1_port) >= NUM_PORTS);
  end else begin : g_port_nochk
    assign port_oor = 1'b0;
  end

  if (NUM_COUNTERS < 256) begin : g_idx_chk
    assign idx_oor = (32'(s1_idx) >= NUM_COUNTERS);
  end else begin : g_idx_nochk
    assign idx_oor = 1'b0;
  end

  logic [CTR_WIDTH-1:0] live_data;

  always_comb begin
    live_data = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int c = 0; c < NUM_COUNTERS; c++) begin
        if (s1_port == PORT_BITS'(p) && s1_idx == 8'(c))
          live_data = perf_in[(p*NUM_COUNTERS+c)*CTR_WIDTH +: CTR_WIDTH];
      end
    end
  end

  logic [CTR_WIDTH-1:0] snap_data [NUM_PORTS];
  logic [NUM_PORTS-1:0] cap_strobe;
  logic [CTR_WIDTH-1:0] snap_sel;

  for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_bank
    perf_snapshot_bank #(
      .NUM_COUNTERS (NUM_COUNTERS),
      .CTR_WIDTH    (CTR_WIDTH)
    ) u_bank (
      .clk     (clk_mgmt),
      .rst_n   (rst_mgmt_n),
      .capture (cap_strobe[gp]),
      .ctr_in  (perf_in[gp*NUM_COUNTERS*CTR_WIDTH +: NUM_COUNTERS*CTR_WIDTH]),
      .rd_idx  (s1_idx),
      .rd_data (snap_data[gp])
    );
  end

  always_comb begin
    snap_sel = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (s1_port == PORT_BITS'(p)) snap_sel = snap_data[p];
    end
  end

  // S2 decode: a capture writes the bank on this edge, so a snapshot read one
  // cycle behind it sees the new contents while one ahead sees the old.
  logic [CTR_WIDTH-1:0] dec_data;
  logic                 dec_err;

  always_comb begin
    dec_data   = '0;
    dec_err    = 1'b0;
    cap_strobe = '0;
    if (s1_valid) begin
      case (decode_region(s1_region))
        OP_LIVE: begin
          if (port_oor || idx_oor) dec_err  = 1'b1;
          else                     dec_data = live_data;
        end
        OP_SNAP: begin
          if (port_oor || idx_oor) dec_err  = 1'b1;
          else                     dec_data = snap_sel;
        end
        OP_CAPTURE: begin
          if (port_oor) begin
            dec_err = 1'b1;
          end else begin
            for (int p = 0; p < NUM_PORTS; p++)
              cap_strobe[p] = (s1_port == PORT_BITS'(p));
          end
        end
        default: dec_err = 1'b1;
      endcase
    end
  end

  logic [NUM_PORTS*NUM_COUNTERS-1:0] clear_next;

`ifdef PERF_CLEAR_ON_READ_EN
  // Successful live reads clear one counter, captures clear the whole port.
  always_comb begin
    clear_next = '0;
    if (s1_valid && !port_oor) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        for (int c = 0; c < NUM_COUNTERS; c++) begin
          if (s1_port == PORT_BITS'(p)) begin
            if (decode_region(s1_region) == OP_LIVE && !idx_oor && s1_idx == 8'(c))
              clear_next[p*NUM_COUNTERS+c] = 1'b1;
            if (decode_region(s1_region) == OP_CAPTURE)
              clear_next[p*NUM_COUNTERS+c] = 1'b1;
          end
        end
      end
    end
  end
`else
  assign clear_next = '0;
`endif

  always_ff @(posedge clk_mgmt) begin
    if (!rst_mgmt_n) begin
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      rd_err     <= 1'b0;
      perf_clear <= '0;
    end else begin
      rd_valid   <= s1_valid;
      perf_clear <= clear_next;
      if (s1_valid) begin
        rd_data <= dec_data;
        rd_err  <= dec_err;
      end
    end
  end

endmodule

// File: tb/tb_multi_port_perf_readout.sv
// Directed bench for multi_port_perf_readout: live, snapshot, ordering, errors,
// reset and clear strobes (clear expectations follow PERF_CLEAR_ON_READ_EN).
module tb_multi_port_perf_readout;
  import perf_readout_pkg::*;

  localparam int NP = 4;
  localparam int NC = 5;
  localparam int W  = 48;
  localparam int PB = 3;

  logic                 clk_mgmt;
  logic                 rst_mgmt_n;
  logic [NP*NC*W-1:0]   perf_in;
  logic                 rd_en;
  logic [PB-1:0]        rd_port;
  logic [15:0]          rd_addr;
  logic                 rd_valid;
  logic [W-1:0]         rd_data;
  logic                 rd_err;
  logic [NP*NC-1:0]     perf_clear;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [W-1:0]     exp_q[$];
  logic             exp_err_q[$];
  logic [NP*NC-1:0] exp_clr_q[$];
  int               iss_q[$];
  string            tag_q[$];

  multi_port_perf_readout #(
    .NUM_PORTS    (NP),
    .NUM_COUNTERS (NC),
    .CTR_WIDTH    (W),
    .PORT_BITS    (PB)
  ) dut (
    .clk_mgmt   (clk_mgmt),
    .rst_mgmt_n (rst_mgmt_n),
    .perf_in    (perf_in),
    .rd_en      (rd_en),
    .rd_port    (rd_port),
    .rd_addr    (rd_addr),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_err     (rd_err),
    .perf_clear (perf_clear)
  );

  // Clock / reset
  initial clk_mgmt = 1'b0;
  always #5 clk_mgmt = ~clk_mgmt;
  always @(posedge clk_mgmt) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] init_val(input int p, input int c);
    return 48'hA000_0000_0000 | W'(p << 8) | W'(c);
  endfunction

  function automatic logic [NP*NC-1:0] clr_live(input int p, input int c);
    logic [NP*NC-1:0] v;
    v = '0;
`ifdef PERF_CLEAR_ON_READ_EN
    v[p*NC+c] = 1'b1;
`endif
    return v;
  endfunction

  function automatic logic [NP*NC-1:0] clr_cap(input int p);
    logic [NP*NC-1:0] v;
    v = '0;
`ifdef PERF_CLEAR_ON_READ_EN
    for (int c = 0; c < NC; c++) v[p*NC+c] = 1'b1;
`endif
    return v;
  endfunction

  // Driver tasks
  task automatic set_ctr(input int p, input int c, input logic [W-1:0] v);
    perf_in[(p*NC+c)*W +: W] = v;
  endtask

  task automatic send(input string tag, input int p, input logic [7:0] region, input int idx,
                      input logic [W-1:0] d, input logic e, input logic [NP*NC-1:0] clr);
    logic [7:0] idx8;
    idx8 = 8'(idx);
    @(negedge clk_mgmt);
    rd_en   = 1'b1;
    rd_port = PB'(p);
    rd_addr = {region, idx8};
    exp_q.push_back(d);
    exp_err_q.push_back(e);
    exp_clr_q.push_back(clr);
    iss_q.push_back(cyc);
    tag_q.push_back(tag);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_mgmt);
      rd_en = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle(1);
    idle(1);
    if (exp_q.size() != 0) check_eq("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard: every rd_valid pops one expectation and checks its latency.
  always @(negedge clk_mgmt) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_valid", 64'(rd_valid), 64'd0);
      end else begin
        string t;
        t = tag_q.pop_front();
        check_eq({t, "_data"},    64'(rd_data),    64'(exp_q.pop_front()));
        check_eq({t, "_err"},     64'(rd_err),     64'(exp_err_q.pop_front()));
        check_eq({t, "_clear"},   64'(perf_clear), 64'(exp_clr_q.pop_front()));
        check_eq({t, "_latency"}, 64'(cyc - iss_q.pop_front()), 64'd2);
      end
    end else begin
      check_eq("clear_idle", 64'(perf_clear), 64'd0);
    end
  end

  initial begin
    rst_mgmt_n = 1'b0;
    rd_en      = 1'b0;
    rd_port    = '0;
    rd_addr    = '0;
    for (int p = 0; p < NP; p++)
      for (int c = 0; c < NC; c++) set_ctr(p, c, init_val(p, c));
    repeat (3) @(negedge clk_mgmt);
    check_eq("reset_valid", 64'(rd_valid), 64'd0);
    check_eq("reset_data",  64'(rd_data),  64'd0);
    check_eq("reset_err",   64'(rd_err),   64'd0);
    rst_mgmt_n = 1'b1;
    idle(2);

    send("snap_never_captured", 3, PERF_REGION_SNAP, REG_RX_FRAMES, '0, 1'b0, '0);
    drain();

    set_ctr(2, REG_RX_CRC_ERRS, 48'h1234);
    send("live_p2c3", 2, PERF_REGION_LIVE, REG_RX_CRC_ERRS, 48'h1234, 1'b0, clr_live(2, 3));
    drain();
    idle(3);
    check_eq("hold_data", 64'(rd_data), 64'h1234);
    check_eq("hold_err",  64'(rd_err),  64'd0);

    set_ctr(1, REG_TX_FRAMES, 48'd100);
    send("cap_p1", 1, PERF_REGION_CAPTURE, 0, '0, 1'b0, clr_cap(1));
    drain();
    set_ctr(1, REG_TX_FRAMES, 48'd500);
    send("snap_p1c0", 1, PERF_REGION_SNAP, REG_TX_FRAMES, 48'd100, 1'b0, '0);
    send("live_p1c0", 1, PERF_REGION_LIVE, REG_TX_FRAMES, 48'd500, 1'b0, clr_live(1, 0));
    send("snap_p1c4", 1, PERF_REGION_SNAP, REG_RX_BYTES, init_val(1, 4), 1'b0, '0);
    send("live_p1c2", 1, PERF_REGION_LIVE, REG_RX_FRAMES, init_val(1, 2), 1'b0, clr_live(1, 2));
    drain();

    set_ctr(0, REG_TX_BYTES, 48'h777);
    send("b2b_cap_p0",  0, PERF_REGION_CAPTURE, 0, '0, 1'b0, clr_cap(0));
    send("b2b_snap_p0", 0, PERF_REGION_SNAP, REG_TX_BYTES, 48'h777, 1'b0, '0);
    send("b2b_live_p3", 3, PERF_REGION_LIVE, REG_RX_BYTES, init_val(3, 4), 1'b0, clr_live(3, 4));
    drain();

    set_ctr(0, REG_TX_BYTES, 48'h888);
    send("snap_before_cap", 0, PERF_REGION_SNAP, REG_TX_BYTES, 48'h777, 1'b0, '0);
    send("recapture_p0",    0, PERF_REGION_CAPTURE, 0, '0, 1'b0, clr_cap(0));
    send("snap_after_cap",  0, PERF_REGION_SNAP, REG_TX_BYTES, 48'h888, 1'b0, '0);
    drain();

    send("err_port4_live",  4, PERF_REGION_LIVE, 0, '0, 1'b1, '0);
    send("err_port5_cap",   5, PERF_REGION_CAPTURE, 0, '0, 1'b1, '0);
    send("err_idx5_live",   0, PERF_REGION_LIVE, 5, '0, 1'b1, '0);
    send("err_idx5_snap",   0, PERF_REGION_SNAP, 5, '0, 1'b1, '0);
    send("err_region20",    0, 8'h20, 0, '0, 1'b1, '0);
    send("err_port7_snap",  7, PERF_REGION_SNAP, 0, '0, 1'b1, '0);
    send("err_region0f",    0, 8'h0F, 3, '0, 1'b1, '0);
    send("ok_after_err",    2, PERF_REGION_LIVE, REG_RX_CRC_ERRS, 48'h1234, 1'b0, clr_live(2, 3));
    drain();

    send("cap_p2",  2, PERF_REGION_CAPTURE, 0, '0, 1'b0, clr_cap(2));
    send("snap_p2", 2, PERF_REGION_SNAP, REG_RX_CRC_ERRS, 48'h1234, 1'b0, '0);
    drain();

    // Request in flight when reset asserts: it must vanish.
    @(negedge clk_mgmt);
    rd_en   = 1'b1;
    rd_port = PB'(0);
    rd_addr = {PERF_REGION_LIVE, 8'h01};
    @(negedge clk_mgmt);
    rd_en      = 1'b0;
    rst_mgmt_n = 1'b0;
    repeat (2) @(negedge clk_mgmt);
    check_eq("midreset_valid", 64'(rd_valid),   64'd0);
    check_eq("midreset_data",  64'(rd_data),    64'd0);
    check_eq("midreset_err",   64'(rd_err),     64'd0);
    check_eq("midreset_clear", 64'(perf_clear), 64'd0);
    rst_mgmt_n = 1'b1;
    idle(4);

    send("snap_p2_after_reset", 2, PERF_REGION_SNAP, REG_RX_CRC_ERRS, '0, 1'b0, '0);
    send("snap_p1_after_reset", 1, PERF_REGION_SNAP, REG_RX_BYTES, '0, 1'b0, '0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
